// File: rtl/lsu_bridge.sv
// lsu_bridge: core load/store to single-outstanding bus bridge with lane shifting, misalignment reject and timeout
module lsu_bridge #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_mem_valid,
  output logic                  o_mem_we,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH:0]   i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] addr_q, addr_d;
  logic [DATA_WIDTH:0] wdata_q, wdata_d, rdata_q, rdata_d, rshift;
  logic [3:0] be_q, be_d;
  logic [7:0] cnt_q, cnt_d;
  logic we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic mis, start, busy, tmo;
  assign mis = i_write_enable && ((i_byte_enable == 4'b0011 && i_write_addr[0]) ||
                                  (i_byte_enable == 4'b1111 && i_write_addr[1:0] != 2'b00));
  assign start = state_q == IDLE && (i_write_enable ? !mis : i_read_req);
  assign busy = state_q == REQ || state_q == WAIT;
  assign tmo = busy && cnt_q >= TLAST;
  assign rshift = i_mem_rdata >> {addr_q[1:0], 3'b000};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          mis_d = mis;
          if (start) begin
            state_d = REQ;
            we_d    = i_write_enable;
            addr_d  = i_write_enable ? i_write_addr : i_read_addr;
            be_d    = i_write_enable ? i_byte_enable << i_write_addr[1:0] : 4'hf;
            wdata_d = i_write_data << {i_write_addr[1:0], 3'b000};
            cnt_d   = '0;
          end
        end
        REQ: begin
          cnt_d = cnt_q + 8'd1;
          if (i_mem_ready) begin
            state_d = (we_q || i_mem_rvalid) ? DONE : WAIT;
            rdata_d = (!we_q && i_mem_rvalid) ? rshift : rdata_q;
          end else if (tmo) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
        WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (i_mem_rvalid) begin
            state_d = DONE;
            rdata_d = rshift;
          end else if (tmo) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    o_mem_valid  = state_q == REQ;
    o_mem_we     = state_q == REQ && we_q;
    o_stall      = !rst && (busy || start);
    o_mem_addr   = {addr_q[ADDR_WIDTH:2], 2'b00};
    o_mem_be     = be_q;
    o_mem_wdata  = wdata_q;
    o_read_data  = rdata_q;
    o_misaligned = mis_q;
    o_bus_err    = err_q;
  end
endmodule

// File: tb/tb_lsu_bridge.sv
// tb_lsu_bridge: directed checks of lsu_bridge with TIMEOUT=4
module tb_lsu_bridge;
  logic clk = 0, rst = 0, clk_en = 1;
  logic i_read_req = 0, i_write_enable = 0, i_mem_ready = 0, i_mem_rvalid = 0;
  logic [31:0] i_read_addr = 0, i_write_addr = 0, i_write_data = 0, i_mem_rdata = 0;
  logic [3:0] i_byte_enable = 0;
  logic [31:0] o_read_data, o_mem_addr, o_mem_wdata;
  logic [3:0] o_mem_be;
  logic o_stall, o_misaligned, o_bus_err, o_mem_valid, o_mem_we;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lsu_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_read_req(i_read_req), .i_read_addr(i_read_addr), .o_read_data(o_read_data),
    .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .o_stall(o_stall), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
    .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    tick();
    tick();
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_mem_valid, 0);
    chk("rst_rdata", o_read_data, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_be", o_mem_be, 0);
    chk("rst_err", o_bus_err, 0);
    rst = 0;
    tick();
    // read 0x102: ready in cycle 2, rvalid in cycle 4
    i_read_req = 1; i_read_addr = 32'h102;
    #1 chk("rd_stall_c1", o_stall, 1);
    chk("rd_valid_c1", o_mem_valid, 0);
    tick();
    i_read_req = 0;
    chk("rd_valid_c2", o_mem_valid, 1);
    chk("rd_addr", o_mem_addr, 32'h100);
    chk("rd_we", o_mem_we, 0);
    chk("rd_stall_c2", o_stall, 1);
    i_mem_ready = 1;
    tick();
    i_mem_ready = 0;
    chk("rd_valid_c3", o_mem_valid, 0);
    chk("rd_stall_c3", o_stall, 1);
    tick();
    chk("rd_stall_c4", o_stall, 1);
    i_mem_rvalid = 1; i_mem_rdata = 32'hAABBCCDD;
    tick();
    i_mem_rvalid = 0;
    chk("rd_stall_done", o_stall, 0);
    chk("rd_data", o_read_data, 32'h0000AABB);
    tick();
    chk("rd_hold", o_read_data, 32'h0000AABB);
    // byte store at 0x203, ready immediate
    i_write_enable = 1; i_byte_enable = 4'b0001; i_write_addr = 32'h203; i_write_data = 32'h5A; i_mem_ready = 1;
    #1 chk("wb_stall_c1", o_stall, 1);
    tick();
    i_write_enable = 0;
    chk("wb_valid", o_mem_valid, 1);
    chk("wb_we", o_mem_we, 1);
    chk("wb_be", o_mem_be, 4'b1000);
    chk("wb_wdata", o_mem_wdata, 32'h5A000000);
    chk("wb_addr", o_mem_addr, 32'h200);
    chk("wb_stall_c2", o_stall, 1);
    tick();
    i_mem_ready = 0;
    chk("wb_stall_done", o_stall, 0);
    chk("wb_valid_done", o_mem_valid, 0);
    tick();
    // misaligned word store at 0x202
    i_write_enable = 1; i_byte_enable = 4'b1111; i_write_addr = 32'h202;
    #1 chk("mis_stall", o_stall, 0);
    tick();
    i_write_enable = 0;
    chk("mis_pulse", o_misaligned, 1);
    chk("mis_valid", o_mem_valid, 0);
    tick();
    chk("mis_pulse_end", o_misaligned, 0);
    chk("mis_valid2", o_mem_valid, 0);
    // misaligned half store at odd address
    i_write_enable = 1; i_byte_enable = 4'b0011; i_write_addr = 32'h201;
    tick();
    i_write_enable = 0;
    chk("mish_pulse", o_misaligned, 1);
    chk("mish_valid", o_mem_valid, 0);
    tick();
    // aligned half store at 0x202
    i_write_enable = 1; i_byte_enable = 4'b0011; i_write_addr = 32'h202; i_write_data = 32'h1234; i_mem_ready = 1;
    tick();
    i_write_enable = 0;
    chk("wh_mis", o_misaligned, 0);
    chk("wh_be", o_mem_be, 4'b1100);
    chk("wh_wdata", o_mem_wdata, 32'h12340000);
    tick();
    i_mem_ready = 0;
    tick();
    // read timeout with ready held low
    i_read_req = 1; i_read_addr = 32'h300;
    tick();
    i_read_req = 0;
    for (int k = 0; k < 3; k++) begin
      chk("to_valid", o_mem_valid, 1);
      chk("to_err_early", o_bus_err, 0);
      tick();
    end
    chk("to_valid_last", o_mem_valid, 1);
    tick();
    chk("to_err", o_bus_err, 1);
    chk("to_valid_drop", o_mem_valid, 0);
    chk("to_rdata", o_read_data, 0);
    chk("to_stall", o_stall, 0);
    tick();
    chk("to_err_end", o_bus_err, 0);
    chk("to_idle_stall", o_stall, 0);
    // simultaneous read and write: write wins
    i_read_req = 1; i_read_addr = 32'h504;
    i_write_enable = 1; i_byte_enable = 4'b1111; i_write_addr = 32'h400; i_write_data = 32'hDEADBEEF;
    tick();
    i_read_req = 0; i_write_enable = 0;
    chk("pri_we", o_mem_we, 1);
    chk("pri_addr", o_mem_addr, 32'h400);
    chk("pri_wdata", o_mem_wdata, 32'hDEADBEEF);
    i_mem_ready = 1;
    tick();
    i_mem_ready = 0;
    tick();
    chk("pri_no_read", o_mem_valid, 0);
    // clk_en low for 3 cycles in WAIT with rvalid held
    i_read_req = 1; i_read_addr = 32'h701;
    tick();
    i_read_req = 0; i_mem_ready = 1;
    tick();
    i_mem_ready = 0; clk_en = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h8899AABB;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ce_stall", o_stall, 1);
      chk("ce_rdata", o_read_data, 0);
    end
    clk_en = 1;
    tick();
    i_mem_rvalid = 0;
    chk("ce_rdata_cap", o_read_data, 32'h008899AA);
    chk("ce_done_stall", o_stall, 0);
    tick();
    // reset in WAIT, then a late response
    i_read_req = 1; i_read_addr = 32'h600;
    tick();
    i_read_req = 0; i_mem_ready = 1;
    tick();
    i_mem_ready = 0;
    chk("rw_stall", o_stall, 1);
    rst = 1;
    #1 chk("rw_async_stall", o_stall, 0);
    chk("rw_async_rdata", o_read_data, 0);
    tick();
    rst = 0;
    i_mem_rvalid = 1; i_mem_rdata = 32'h11223344;
    tick();
    tick();
    i_mem_rvalid = 0;
    chk("rw_late_rdata", o_read_data, 0);
    chk("rw_late_valid", o_mem_valid, 0);
    chk("rw_late_stall", o_stall, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
